// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - shared types and default timing constants for the wash panel
package wash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    PAUSED,
    ABORT,
    FAULT
  } panel_state_t;

  // Defaults shared with the machine controller bench
  localparam int DEF_DEB_CYCLES  = 4;
  localparam int DEF_WDOG_CYCLES = 64;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button debouncer with single-cycle press event
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          level_q;

  // Count consecutive samples that disagree with the level; flip on the DEB_CYCLES-th one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (raw == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      level <= raw;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Previous debounced level, for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/wash_panel_ctrl.sv
// rtl/wash_panel_ctrl.sv - wash panel FSM, option latches, watchdog and cycle counter
module wash_panel_ctrl
  import wash_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_double,
  input  logic             btn_dry,
  input  logic             btn_pause,
  input  logic             btn_stop,
  input  logic             done,
  output logic             start,
  output logic             double_wash,
  output logic             dry_wash,
  output logic             time_pause,
  output logic             stop,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] cycles_done
);

  localparam int              WD_W    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  panel_state_t     state, state_n;
  logic [WD_W-1:0]  wdog;
  logic             opt_double, opt_dry;
  logic [CNT_W-1:0] cnt;

  logic [4:0] raw_btn, btn_level, btn_press, ev;
  logic       ev_start, ev_double, ev_dry, ev_pause, ev_stop;

  assign raw_btn = {btn_stop, btn_pause, btn_dry, btn_double, btn_start};

  for (genvar i = 0; i < 5; i++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_btn[i]),
      .level (btn_level[i]),
      .press (btn_press[i])
    );
  end

  // Press events, qualified by the debounced level they rose from
  assign ev        = btn_press & btn_level;
  assign ev_start  = ev[0];
  assign ev_double = ev[1];
  assign ev_dry    = ev[2];
  assign ev_pause  = ev[3];
  assign ev_stop   = ev[4];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; done outranks stop, watchdog and pause in RUN/PAUSED
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (ev_start) state_n = ARM;
      ARM:    state_n = RUN;
      RUN: begin
        if (done)                 state_n = IDLE;
        else if (ev_stop)         state_n = ABORT;
        else if (wdog == WD_LAST) state_n = FAULT;
        else if (ev_pause)        state_n = PAUSED;
      end
      PAUSED: begin
        if (done)          state_n = IDLE;
        else if (ev_stop)  state_n = ABORT;
        else if (ev_pause) state_n = RUN;
      end
      ABORT:  state_n = IDLE;
      FAULT:  if (ev_stop) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Options toggle only in IDLE, so they stay frozen for the whole wash
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opt_double <= 1'b0;
      opt_dry    <= 1'b0;
    end else if (state == IDLE) begin
      if (ev_double) opt_double <= ~opt_double;
      if (ev_dry)    opt_dry    <= ~opt_dry;
    end
  end

  // Watchdog: cleared on ARM, counts RUN cycles, frozen everywhere else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wdog <= '0;
    else if (state == ARM)  wdog <= '0;
    else if (state == RUN)  wdog <= wdog + WD_W'(1);
  end

  // Completed-cycle counter, wrapping; only done seen in RUN/PAUSED counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           cnt <= '0;
    else if (done && (state == RUN || state == PAUSED)) cnt <= cnt + CNT_W'(1);
  end

  assign start       = (state == ARM);
  assign time_pause  = (state == PAUSED);
  assign stop        = (state == ABORT) || (state == FAULT);
  assign busy        = (state == ARM) || (state == RUN) || (state == PAUSED) || (state == ABORT);
  assign fault       = (state == FAULT);
  assign double_wash = opt_double;
  assign dry_wash    = opt_dry;
  assign cycles_done = cnt;

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// tb/tb_wash_panel_ctrl.sv - scenario bench for wash_panel_ctrl with cycle-count scoreboard
module tb_wash_panel_ctrl;

  localparam int DEB  = 4;
  localparam int WDOG = 64;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    btn = '0;
  logic          done = 1'b0;
  logic          start, double_wash, dry_wash, time_pause, stop, busy, fault;
  logic [CW-1:0] cycles_done;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [CW-1:0] sb_q[$];

  wash_panel_ctrl #(.DEB_CYCLES(DEB), .WDOG_CYCLES(WDOG), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_start   (btn[0]),
    .btn_double  (btn[1]),
    .btn_dry     (btn[2]),
    .btn_pause   (btn[3]),
    .btn_stop    (btn[4]),
    .done        (done),
    .start       (start),
    .double_wash (double_wash),
    .dry_wash    (dry_wash),
    .time_pause  (time_pause),
    .stop        (stop),
    .busy        (busy),
    .fault       (fault),
    .cycles_done (cycles_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_btn(input int idx, input int n);
    btn[idx] = 1'b1;
    repeat (n) step();
    btn[idx] = 1'b0;
  endtask

  task automatic settle();
    repeat (DEB + 2) step();
  endtask

  // Leaves the bench just after the ARM->RUN edge
  task automatic start_run();
    pulse_btn(0, DEB);
    step();
    step();
  endtask

  task automatic push_done();
    exp_cnt = exp_cnt + 1'b1;
    sb_q.push_back(exp_cnt);
    done = 1'b1;
  endtask

  task automatic test_reset();
    logic [CW+6:0] outs;
    step();
    outs = {start, double_wash, dry_wash, time_pause, stop, busy, fault, cycles_done};
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL reset_held: got %0h expected 0", outs); end
    rst = 1'b0;
    step();
    outs = {start, double_wash, dry_wash, time_pause, stop, busy, fault, cycles_done};
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL reset_release: got %0h expected 0", outs); end
  endtask

  task automatic test_short_press();
    logic seen;
    seen = 1'b0;
    btn[0] = 1'b1;
    repeat (2) step();
    btn[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      done = (i == 3);
      step();
      seen = seen | start | busy;
    end
    done = 1'b0;
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL short_press: got start/busy seen=%0b expected 0", seen); end
    n_cmp++;
    if (cycles_done !== exp_cnt) begin n_bad++; $display("FAIL idle_done: got %0d expected %0d", cycles_done, exp_cnt); end
  endtask

  task automatic test_double_start();
    logic          bad;
    logic [CW-1:0] e;
    pulse_btn(1, DEB);
    step();
    n_cmp++;
    if ({double_wash, dry_wash} !== 2'b10) begin n_bad++; $display("FAIL double_toggle: got %b expected 10", {double_wash, dry_wash}); end
    settle();
    btn[0] = 1'b1;
    for (int ed = 1; ed <= 8; ed++) begin
      step();
      if (ed == DEB) btn[0] = 1'b0;
      n_cmp++;
      if (start !== (ed == DEB + 1)) begin n_bad++; $display("FAIL start_edge%0d: got %0b expected %0b", ed, start, ed == DEB + 1); end
    end
    bad = 1'b0;
    repeat (10) begin
      step();
      if (double_wash !== 1'b1 || busy !== 1'b1) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_bad++; $display("FAIL double_held: got unstable double_wash/busy expected 1"); end
    push_done();
    step();
    done = 1'b0;
    e = sb_q.pop_front();
    n_cmp++;
    if (busy !== 1'b0 || cycles_done !== e) begin n_bad++; $display("FAIL first_done: got busy=%0b cnt=%0d expected busy=0 cnt=%0d", busy, cycles_done, e); end
  endtask

  task automatic test_pause_resume();
    logic          bad;
    logic [CW-1:0] e;
    settle();
    start_run();
    pulse_btn(1, DEB);
    step();
    n_cmp++;
    if (double_wash !== 1'b1) begin n_bad++; $display("FAIL double_in_run: got %0b expected 1", double_wash); end
    settle();
    pulse_btn(3, DEB);
    n_cmp++;
    if (time_pause !== 1'b0) begin n_bad++; $display("FAIL pause_early: got %0b expected 0", time_pause); end
    step();
    n_cmp++;
    if (time_pause !== 1'b1) begin n_bad++; $display("FAIL pause_enter: got %0b expected 1", time_pause); end
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      btn[0] = (i < DEB);
      step();
      if (time_pause !== 1'b1 || fault !== 1'b0 || stop !== 1'b0 || start !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    btn[0] = 1'b0;
    n_cmp++;
    if (bad) begin n_bad++; $display("FAIL paused_hold: got state change while paused expected steady PAUSED"); end
    pulse_btn(3, DEB);
    step();
    n_cmp++;
    if ({time_pause, busy} !== 2'b01) begin n_bad++; $display("FAIL resume: got pause/busy=%b expected 01", {time_pause, busy}); end
    push_done();
    step();
    done = 1'b0;
    e = sb_q.pop_front();
    n_cmp++;
    if (busy !== 1'b0 || fault !== 1'b0 || cycles_done !== e) begin n_bad++; $display("FAIL pause_done: got busy=%0b fault=%0b cnt=%0d expected 0 0 %0d", busy, fault, cycles_done, e); end
  endtask

  task automatic test_done_vs_stop();
    logic          seen;
    logic [CW-1:0] e;
    settle();
    start_run();
    pulse_btn(4, DEB);
    push_done();
    step();
    done = 1'b0;
    e = sb_q.pop_front();
    seen = stop;
    n_cmp++;
    if (busy !== 1'b0 || cycles_done !== e) begin n_bad++; $display("FAIL done_beats_stop: got busy=%0b cnt=%0d expected 0 %0d", busy, cycles_done, e); end
    repeat (4) begin step(); seen = seen | stop; end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL no_stop_pulse: got %0b expected 0", seen); end
  endtask

  task automatic test_watchdog();
    int   run_cnt;
    logic got, paused_seen;
    settle();
    start_run();
    run_cnt     = 0;
    got         = 1'b0;
    paused_seen = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (fault) got = 1'b1;
      else begin
        if (busy && !start && !time_pause && !stop) run_cnt++;
        if (time_pause) paused_seen = 1'b1;
        btn[3] = (i >= 20 && i < 20 + DEB) || (i >= 60 && i < 60 + DEB);
        step();
      end
    end
    btn[3] = 1'b0;
    n_cmp++;
    if (got !== 1'b1 || run_cnt != WDOG) begin n_bad++; $display("FAIL wdog_expiry: got fault=%0b run_cycles=%0d expected 1 %0d", got, run_cnt, WDOG); end
    n_cmp++;
    if (paused_seen !== 1'b1 || stop !== 1'b1) begin n_bad++; $display("FAIL wdog_stop: got paused_seen=%0b stop=%0b expected 1 1", paused_seen, stop); end
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    n_cmp++;
    if (fault !== 1'b1 || cycles_done !== exp_cnt) begin n_bad++; $display("FAIL fault_ignores_done: got fault=%0b cnt=%0d expected 1 %0d", fault, cycles_done, exp_cnt); end
    pulse_btn(4, DEB);
    step();
    n_cmp++;
    if ({fault, stop, busy} !== 3'b000) begin n_bad++; $display("FAIL fault_clear: got %b expected 000", {fault, stop, busy}); end
  endtask

  task automatic test_wrap_and_reset();
    logic [CW-1:0] e;
    logic [CW+6:0] outs;
    settle();
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 300 && (pass == 1 ? exp_cnt != 8'hFF : !(exp_cnt == 8'h00 && k > 0)); k++) begin
        pulse_btn(0, DEB);
        step();
        step();
        push_done();
        step();
        done = 1'b0;
        e = sb_q.pop_front();
        n_cmp++;
        if (cycles_done !== e) begin n_bad++; $display("FAIL count_cycle: got %0d expected %0d", cycles_done, e); end
        step();
        step();
      end
    end
    n_cmp++;
    if (cycles_done !== 8'hFF) begin n_bad++; $display("FAIL count_at_max: got %0d expected 255", cycles_done); end
    start_run();
    repeat (5) step();
    rst = 1'b1;
    #1;
    outs = {start, double_wash, dry_wash, time_pause, stop, busy, fault, cycles_done};
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL async_reset: got %0h expected 0", outs); end
    step();
    rst     = 1'b0;
    exp_cnt = '0;
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_double_start();
    test_pause_resume();
    test_done_vs_stop();
    test_watchdog();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
